integ_sequencer: RTL and testbench

- Controller that sequences one Integradorv2 instance (ports a, dt, enable, rst, clk, v, busy) for the odometry path of the vacuum cleaner J1 SoC.
- Generates the sample tick from a CPU-programmable period, samples the acceleration input and starts one integration per tick.
- Waits for the integrator's busy handshake, latches the velocity result and flags overruns and timeouts.
- Configured by the J1 through a small 3-register write port.

---
 rtl/integ_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_integ_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/integ_sequencer.sv
// -----------------------------------------------------------------------------
// integ_sequencer
//
// Sequences one Integradorv2 instance for the odometry path. A programmable
// down-counter produces a sample tick. Each tick captures the acceleration
// sample and starts one integration. The block then follows the integrator's
// busy handshake and latches the velocity result. Overruns (a tick that
// arrives mid-operation) and busy timeouts are recorded in sticky flags.
//
// Optional feature, selected by the INTEG_DEADBAND_EN macro:
//   defined   - samples with |accel| < DEADBAND are sent to the integrator
//               as 0. 16'h8000 passes through unchanged.
//   undefined - accel is passed through unchanged.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   cfg_we/addr/wdata config write port (0=period, 1=dt, 2=control)
//                     control bit0 = clear integrator, bit1 = clear error flags
//   run               enables tick generation
//   accel             signed acceleration sample source
//   int_a/int_dt      operands presented to the integrator
//   int_enable        one-cycle start pulse to the integrator
//   int_rst           integrator reset (rst OR a registered clear pulse)
//   int_v/int_busy    integrator result and busy handshake
//   vel/vel_valid     latched velocity and its one-cycle update strobe
//   overrun           sticky: a tick arrived while an operation was running
//   timeout_err       sticky: busy stayed high for TIMEOUT cycles
//   active            high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module integ_sequencer #(
   parameter int          BUSY_WAIT = 4,
   parameter int          TIMEOUT   = 1024,
   parameter logic [15:0] DEADBAND  = 16'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_addr,
   input  logic [15:0] cfg_wdata,
   input  logic        run,
   input  logic [15:0] accel,
   output logic [15:0] int_a,
   output logic [15:0] int_dt,
   output logic        int_enable,
   output logic        int_rst,
   input  logic [15:0] int_v,
   input  logic        int_busy,
   output logic [15:0] vel,
   output logic        vel_valid,
   output logic        overrun,
   output logic        timeout_err,
   output logic        active
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_LATCH     = 3'd4,
      S_CLEAR     = 3'd5
   } state_t;

   // One counter serves both wait states, so it must hold the larger limit.
   localparam int             WMAX      = (TIMEOUT > BUSY_WAIT) ? TIMEOUT : BUSY_WAIT;
   localparam int             WCW       = $clog2(WMAX + 1);
   localparam logic [WCW-1:0] BUSY_LAST = WCW'(BUSY_WAIT);
   localparam logic [WCW-1:0] DONE_LAST = WCW'(TIMEOUT - 1);

   // Magnitude compare against DEADBAND. 16'h8000 negates to itself, and that
   // value compares as a large unsigned number, so it is never zeroed.
   function automatic logic [15:0] deadband_f(input logic [15:0] x);
      logic [15:0] mag;
      if (x[15]) begin
         mag = 16'd0 - x;
      end else begin
         mag = x;
      end
      if (mag < DEADBAND) begin
         deadband_f = 16'd0;
      end else begin
         deadband_f = x;
      end
   endfunction

   state_t         state_q, state_d;
   logic [15:0]    period_q, period_d;
   logic [15:0]    dt_reg_q, dt_reg_d;
   logic [15:0]    cnt_q, cnt_d;
   logic           run_q;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic [15:0]    int_a_q, int_a_d;
   logic [15:0]    int_dt_q, int_dt_d;
   logic           int_en_q, int_en_d;
   logic           clr_pulse_q, clr_pulse_d;
   logic [15:0]    vel_q, vel_d;
   logic           vel_valid_q, vel_valid_d;
   logic           overrun_q, overrun_d;
   logic           timeout_q, timeout_d;
   logic           clr_pend_q, clr_pend_d;
   logic           active_q, active_d;

   logic           per_we_s, dt_we_s, ctl_we_s;
   logic [15:0]    per_wdata_s;
   logic [15:0]    reload_s;
   logic           run_rise_s;
   logic           tick_s;
   logic [15:0]    a_start_s;

`ifdef INTEG_DEADBAND_EN
   assign a_start_s = deadband_f(accel);
`else
   assign a_start_s = accel;
`endif

   // Config decode; periods below 2 are clamped so the counter always wraps.
   always_comb begin
      per_we_s = cfg_we & (cfg_addr == 2'd0);
      dt_we_s  = cfg_we & (cfg_addr == 2'd1);
      ctl_we_s = cfg_we & (cfg_addr == 2'd2);
      if (cfg_wdata < 16'd2) begin
         per_wdata_s = 16'd2;
      end else begin
         per_wdata_s = cfg_wdata;
      end
      if (per_we_s) begin
         period_d = per_wdata_s;
      end else begin
         period_d = period_q;
      end
      if (dt_we_s) begin
         dt_reg_d = cfg_wdata;
      end else begin
         dt_reg_d = dt_reg_q;
      end
   end

   // Tick timer: down-counter reloaded on run rise, wrap and period writes.
   always_comb begin
      run_rise_s = run & ~run_q;
      reload_s   = period_q - 16'd1;
      tick_s     = run & (cnt_q == 16'd0);
      if (!run) begin
         cnt_d = reload_s;
      end else if (per_we_s) begin
         cnt_d = per_wdata_s - 16'd1;
      end else if (run_rise_s || (cnt_q == 16'd0)) begin
         cnt_d = reload_s;
      end else begin
         cnt_d = cnt_q - 16'd1;
      end
   end

   // Sequencer next state. Outputs are computed for the state being entered,
   // so every output is a flop that is valid during that state.
   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      int_a_d     = int_a_q;
      int_dt_d    = int_dt_q;
      int_en_d    = 1'b0;
      clr_pulse_d = 1'b0;
      vel_d       = vel_q;
      vel_valid_d = 1'b0;
      overrun_d   = overrun_q;
      timeout_d   = timeout_q;
      clr_pend_d  = clr_pend_q;

      case (state_q)
         S_IDLE: begin
            // A pending clear wins; a tick in the same cycle is dropped quietly.
            if (clr_pend_q) begin
               state_d     = S_CLEAR;
               clr_pend_d  = 1'b0;
               clr_pulse_d = 1'b1;
               vel_d       = 16'd0;
            end else if (tick_s) begin
               state_d  = S_START;
               int_a_d  = a_start_s;
               int_dt_d = dt_reg_q;
               int_en_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            state_d = S_WAIT_BUSY;
            wcnt_d  = {WCW{1'b0}};
         end
         S_WAIT_BUSY: begin
            // No busy within the window means a single-cycle integrator.
            if (int_busy) begin
               state_d = S_WAIT_DONE;
               wcnt_d  = {WCW{1'b0}};
            end else if (wcnt_q == BUSY_LAST) begin
               state_d     = S_LATCH;
               vel_d       = int_v;
               vel_valid_d = 1'b1;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!int_busy) begin
               state_d     = S_LATCH;
               vel_d       = int_v;
               vel_valid_d = 1'b1;
            end else if (wcnt_q == DONE_LAST) begin
               state_d     = S_CLEAR;
               timeout_d   = 1'b1;
               clr_pulse_d = 1'b1;
               vel_d       = 16'd0;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         S_LATCH: begin
            state_d = S_IDLE;
         end
         S_CLEAR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (tick_s && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_d;
      end

      // Control writes are applied last so they win over same-cycle events.
      if (ctl_we_s && cfg_wdata[1]) begin
         overrun_d = 1'b0;
         timeout_d = 1'b0;
      end else begin
         overrun_d = overrun_d;
      end
      if (ctl_we_s && cfg_wdata[0]) begin
         clr_pend_d = 1'b1;
      end else begin
         clr_pend_d = clr_pend_d;
      end

      active_d = (state_d != S_IDLE);
   end

   // All sequencer state, including the registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         period_q    <= 16'd1000;
         dt_reg_q    <= 16'd10;
         cnt_q       <= 16'd999;
         run_q       <= 1'b0;
         wcnt_q      <= {WCW{1'b0}};
         int_a_q     <= 16'd0;
         int_dt_q    <= 16'd10;
         int_en_q    <= 1'b0;
         clr_pulse_q <= 1'b0;
         vel_q       <= 16'd0;
         vel_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
         clr_pend_q  <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         dt_reg_q    <= dt_reg_d;
         cnt_q       <= cnt_d;
         run_q       <= run;
         wcnt_q      <= wcnt_d;
         int_a_q     <= int_a_d;
         int_dt_q    <= int_dt_d;
         int_en_q    <= int_en_d;
         clr_pulse_q <= clr_pulse_d;
         vel_q       <= vel_d;
         vel_valid_q <= vel_valid_d;
         overrun_q   <= overrun_d;
         timeout_q   <= timeout_d;
         clr_pend_q  <= clr_pend_d;
         active_q    <= active_d;
      end
   end

   assign int_a       = int_a_q;
   assign int_dt      = int_dt_q;
   assign int_enable  = int_en_q;
   // The integrator must be held in reset while the sequencer itself is.
   assign int_rst     = rst | clr_pulse_q;
   assign vel         = vel_q;
   assign vel_valid   = vel_valid_q;
   assign overrun     = overrun_q;
   assign timeout_err = timeout_q;
   assign active      = active_q;

endmodule

// File: tb/tb_integ_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for integ_sequencer. A small integrator model answers each start
// pulse with busy for busy_len cycles and v = a + dt. Each start pushes the
// expected velocity and latency onto a scoreboard, and a monitor pops that
// entry when vel_valid appears. Directed phases check the timer, overrun,
// timeout, clear and reset behaviour.
// -----------------------------------------------------------------------------
module tb_integ_sequencer;

   localparam int BUSY_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = 2'd0;
   logic [15:0] cfg_wdata = 16'd0;
   logic        run = 1'b0;
   logic [15:0] accel = 16'h00AA;
   logic [15:0] int_a, int_dt, int_v, vel;
   logic        int_enable, int_rst, int_busy, vel_valid, overrun, timeout_err, active;

   integ_sequencer dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .run(run), .accel(accel), .int_a(int_a), .int_dt(int_dt), .int_enable(int_enable),
      .int_rst(int_rst), .int_v(int_v), .int_busy(int_busy), .vel(vel), .vel_valid(vel_valid),
      .overrun(overrun), .timeout_err(timeout_err), .active(active)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Integrator model
   int          busy_len   = 5;
   logic        busy_stuck = 1'b0;
   int          bcnt;
   logic [15:0] v_model;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt    <= 0;
         v_model <= 16'd0;
      end else if (int_enable) begin
         bcnt    <= busy_len;
         v_model <= int_a + int_dt;
      end else if (bcnt != 0) begin
         bcnt <= bcnt - 1;
      end
   end
   assign int_busy = busy_stuck | (bcnt != 0);
   assign int_v    = v_model;

   // Scoreboard
   typedef struct {
      logic [15:0] vel;
      int          lat;
      int          cyc;
   } exp_t;
   exp_t        sb_q[$];
   exp_t        e_push, e_pop;
   logic [15:0] exp_a  = 16'h00AA;
   logic [15:0] exp_dt = 16'd10;
   logic        no_vel = 1'b0;
   int          n_en = 0, last_en = 0, en_gap = 0;

   always @(negedge clk) begin
      if (!rst && int_enable) begin
         check("start_int_a", 32'(int_a), 32'(exp_a));
         check("start_int_dt", 32'(int_dt), 32'(exp_dt));
         en_gap  = cyc - last_en;
         last_en = cyc;
         n_en    = n_en + 1;
         if (!no_vel) begin
            e_push.vel = exp_a + exp_dt;
            e_push.lat = (busy_len > 0) ? busy_len + 2 : BUSY_WAIT + 2;
            e_push.cyc = cyc;
            sb_q.push_back(e_push);
         end
      end
      if (!rst && vel_valid) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL vel_valid_unexpected: got vel %0h with nothing expected (cycle %0d)", vel, cyc);
         end else begin
            e_pop = sb_q.pop_front();
            check("vel_value", 32'(vel), 32'(e_pop.vel));
            check("vel_latency_from_start", 32'(cyc - e_pop.cyc), 32'(e_pop.lat));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   // Returns #1 after the edge that follows the enable cycle.
   task automatic wait_en(input string name, input int budget);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (int_enable) begin
            seen = 1'b1;
            break;
         end
      end
      check(name, 32'(seen), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_int_a"}, 32'(int_a), 32'h0);
      check({tag, "_int_dt"}, 32'(int_dt), 32'd10);
      check({tag, "_int_enable"}, 32'(int_enable), 32'd0);
      check({tag, "_int_rst"}, 32'(int_rst), 32'd1);
      check({tag, "_vel"}, 32'(vel), 32'h0);
      check({tag, "_vel_valid"}, 32'(vel_valid), 32'd0);
      check({tag, "_overrun"}, 32'(overrun), 32'd0);
      check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
      check({tag, "_active"}, 32'(active), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      // Reset values
      #1 rst = 1'b1;
      #2 check_reset("reset");
      step(2);
      rst = 1'b0;
      step(1);

      // Period 20, busy 5, dt write mid-operation
      busy_len = 5; n_en = 0;
      cfg_write(2'd0, 16'd20);
      run = 1'b1;
      step(44);
      cfg_write(2'd1, 16'd3);
      check("dt_write_mid_op_int_dt", 32'(int_dt), 32'd10);
      exp_dt = 16'd3;
      step(25);
      run = 1'b0;
      step(10);
      check("p20_start_count", 32'(n_en), 32'd3);
      check("p20_start_spacing", 32'(en_gap), 32'd20);
      check("p20_int_a_held", 32'(int_a), 32'h00AA);
      check("p20_int_dt_new", 32'(int_dt), 32'd3);
      check("p20_overrun", 32'(overrun), 32'd0);
      check("p20_sb_empty", 32'(sb_q.size()), 32'd0);
      cfg_write(2'd1, 16'd10);
      exp_dt = 16'd10;

      // Period 4, busy 6: overlapping ticks are dropped and flagged
      busy_len = 6; n_en = 0;
      cfg_write(2'd0, 16'd4);
      run = 1'b1;
      step(30);
      run = 1'b0;
      step(15);
      check("ovr_start_count", 32'(n_en), 32'd3);
      check("ovr_start_spacing", 32'(en_gap), 32'd12);
      check("ovr_flag_set", 32'(overrun), 32'd1);
      cfg_write(2'd2, 16'h0002);
      check("ovr_flag_cleared", 32'(overrun), 32'd0);
      check("ovr_sb_empty", 32'(sb_q.size()), 32'd0);

      // Period write of 0 clamps to 2; integrator never asserts busy
      busy_len = 0; n_en = 0;
      cfg_write(2'd0, 16'd0);
      run = 1'b1;
      step(30);
      run = 1'b0;
      step(12);
      check("p0_start_count", 32'(n_en), 32'd4);
      check("p0_start_spacing", 32'(en_gap), 32'd8);
      check("p0_overrun", 32'(overrun), 32'd1);
      cfg_write(2'd2, 16'h0002);
      check("p0_sb_empty", 32'(sb_q.size()), 32'd0);

      // Busy stuck high: timeout, one clear pulse, then normal operation
      cfg_write(2'd0, 16'd2000);
      busy_stuck = 1'b1; no_vel = 1'b1;
      run = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 3200; k++) begin
         @(negedge clk);
         if (int_rst) begin
            seen = 1'b1;
            break;
         end
      end
      check("to_clear_pulse_seen", 32'(seen), 32'd1);
      check("to_timeout_err", 32'(timeout_err), 32'd1);
      check("to_vel_zero", 32'(vel), 32'h0);
      check("to_active_in_clear", 32'(active), 32'd1);
      busy_stuck = 1'b0; no_vel = 1'b0;
      @(negedge clk);
      check("to_clear_single_cycle", 32'(int_rst), 32'd0);
      @(posedge clk); #1;
      wait_en("to_next_start", 1100);
      step(10);
      run = 1'b0;
      check("to_sb_empty", 32'(sb_q.size()), 32'd0);
      check("to_err_sticky", 32'(timeout_err), 32'd1);
      check("to_overrun", 32'(overrun), 32'd0);
      cfg_write(2'd2, 16'h0002);
      check("to_err_cleared", 32'(timeout_err), 32'd0);

      // Clear requested during WAIT_DONE; coincident tick on return to IDLE
      busy_len = 5; n_en = 0;
      cfg_write(2'd0, 16'd9);
      run = 1'b1;
      wait_en("clr_first_start", 50);
      step(1);
      cfg_write(2'd2, 16'h0001);
      step(6);
      check("clr_int_rst_pulse", 32'(int_rst), 32'd1);
      check("clr_vel_zero", 32'(vel), 32'h0);
      check("clr_active", 32'(active), 32'd1);
      step(1);
      check("clr_int_rst_single", 32'(int_rst), 32'd0);
      check("clr_no_overrun", 32'(overrun), 32'd0);
      step(9);
      check("clr_tick_dropped_gap", 32'(en_gap), 32'd18);
      run = 1'b0;
      step(12);
      check("clr_overrun_end", 32'(overrun), 32'd0);
      check("clr_sb_empty", 32'(sb_q.size()), 32'd0);

      // Deadband vectors (pass-through in the default build)
      cfg_write(2'd0, 16'd20);
      accel = 16'h0003;
`ifdef INTEG_DEADBAND_EN
      exp_a = 16'h0000;
`else
      exp_a = 16'h0003;
`endif
      run = 1'b1;
      wait_en("db_start_small", 50);
      accel = 16'hFFFC; exp_a = 16'hFFFC;
      wait_en("db_start_neg4", 50);
      accel = 16'h8000; exp_a = 16'h8000;
      wait_en("db_start_min", 50);
      step(10);
      run = 1'b0;
      step(5);
      check("db_sb_empty", 32'(sb_q.size()), 32'd0);

      // Async reset mid-WAIT_DONE, then resume from IDLE
      cfg_write(2'd1, 16'd7);
      exp_dt = 16'd7;
      busy_len = 30;
      accel = 16'h0055; exp_a = 16'h0055;
      run = 1'b1;
      wait_en("rst_start", 50);
      step(24);
      check("rst_pre_active", 32'(active), 32'd1);
      check("rst_pre_overrun", 32'(overrun), 32'd1);
      check("rst_pre_int_dt", 32'(int_dt), 32'd7);
      rst = 1'b1;
      #1 check_reset("rst_mid");
      sb_q.delete();
      exp_dt = 16'd10;
      busy_len = 5;
      step(2);
      rst = 1'b0;
      wait_en("rst_resume_start", 1100);
      step(10);
      run = 1'b0;
      check("rst_resume_sb_empty", 32'(sb_q.size()), 32'd0);
      check("rst_resume_overrun", 32'(overrun), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
